// File: rtl/elevator_pkg.sv
// Shared elevator types: floor number width and car direction encoding.
package elevator_pkg;

  localparam int NUM_FLOORS = 8;

  typedef logic [3:0] floor_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DOWN = 2'b01,
    UP   = 2'b11
  } dir_t;

endpackage

// File: rtl/btn_conditioner.sv
// One call button: 2-flop synchronizer, optional debounce (REQ_DEBOUNCE_EN), and a
// registered rising-edge detector that emits a single-cycle press pulse.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync1_q, sync2_q;
  logic prime1_q, prime2_q;
  logic armed_q, prev_q, press_q;
  logic level;

`ifdef REQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) filt_d = sync2_q;
      else                                   cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  // A press only counts once a genuine synchronized low has been seen after reset, so a
  // button held through reset never fires; prime*_q marks when sync2_q holds a real sample.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prime1_q <= 1'b0;
      prime2_q <= 1'b0;
      armed_q  <= 1'b0;
      prev_q   <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      prime1_q <= 1'b1;
      prime2_q <= prime1_q;
      armed_q  <= armed_q | (prime2_q & ~sync2_q);
      prev_q   <= level;
      press_q  <= level & ~prev_q & armed_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/call_request_queue.sv
// Elevator hall-call queue: conditions buttons, serialises arrivals one floor per cycle,
// and presents pending floors in arrival order. Optional debounce via REQ_DEBOUNCE_EN.
module call_request_queue #(
  parameter int NUM_FLOORS      = elevator_pkg::NUM_FLOORS,
  parameter int FIFO_DEPTH      = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] btn,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [3:0]            req_floor,
  input  logic                  svc_valid,
  input  logic [2:0]            svc_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [3:0]            count,
  output logic                  overflow
);

  import elevator_pkg::*;

  localparam int                    PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);

  if (FIFO_DEPTH != NUM_FLOORS) begin : g_depth_check
    $error("FIFO_DEPTH must equal NUM_FLOORS");
  end

  logic [NUM_FLOORS-1:0] press;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn[i]),
      .press_o (press[i])
    );
  end

  logic [NUM_FLOORS-1:0] arrive_q, arrive_d, pending_q, pending_d, queued_q, queued_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]            count_q, count_d;
  logic                  overflow_q, overflow_d;
  floor_t                fifo_q [FIFO_DEPTH];

  floor_t                arr_floor, head;
  logic [NUM_FLOORS-1:0] arr_mask, head_mask, pop_mask, svc_mask, queued_eff;
  logic                  not_empty, head_live, pop, push, push_ok, full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    arr_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (arrive_q[i]) arr_floor = floor_t'(i);
    end
    arr_mask  = (|arrive_q) ? (ONE << arr_floor) : '0;

    head      = fifo_q[rd_ptr_q];
    head_mask = ONE << head;
    not_empty = (count_q != 4'd0);
    head_live = |(pending_q & head_mask);
    req_valid = not_empty && head_live;
    req_floor = not_empty ? head : '0;
    // Stale heads pop without waiting for req_ready; live heads pop on the handshake.
    pop       = not_empty && (!head_live || req_ready);
    pop_mask  = pop ? head_mask : '0;

    svc_mask  = (svc_valid && (32'(svc_floor) < NUM_FLOORS)) ? (ONE << svc_floor) : '0;

    // A floor popped this cycle is no longer queued, so a same-cycle arrival re-queues it.
    queued_eff = queued_q & ~pop_mask;
    push       = (|arr_mask) && !(|(queued_eff & arr_mask));
    full       = (count_q == 4'(FIFO_DEPTH));
    push_ok    = push && (!full || pop);

    arrive_d   = (arrive_q & ~arr_mask) | press;
    pending_d  = (pending_q & ~svc_mask) | arr_mask;
    queued_d   = queued_eff | arr_mask;
    overflow_d = overflow_q | (push && full && !pop);
    wr_ptr_d   = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + 4'd1;
    else if (pop && !push_ok) count_d = count_q - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arrive_q   <= '0;
      pending_q  <= '0;
      queued_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      arrive_q   <= arrive_d;
      pending_q  <= pending_d;
      queued_q   <= queued_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: FIFO storage has no reset; count_q gates every read, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= arr_floor;
  end

  assign pending  = pending_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_call_request_queue.sv
// Directed self-checking bench for call_request_queue; latencies follow REQ_DEBOUNCE_EN.
module tb_call_request_queue;

`ifdef REQ_DEBOUNCE_EN
  localparam int LAT = 4 + 4;
`else
  localparam int LAT = 4;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] btn;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_floor;
  logic       svc_valid;
  logic [2:0] svc_floor;
  logic [7:0] pending;
  logic [3:0] count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  call_request_queue dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_floor (req_floor),
    .svc_valid (svc_valid),
    .svc_floor (svc_floor),
    .pending   (pending),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic service(input logic [2:0] f);
    svc_valid = 1'b1;
    svc_floor = f;
    step();
    svc_valid = 1'b0;
    svc_floor = '0;
  endtask

  initial begin
    rst = 1'b0; btn = '0; req_ready = 1'b0; svc_valid = 1'b0; svc_floor = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_count", count, 0);
    check("rst_valid", req_valid, 0);
    check("rst_pending", pending, 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (4) step();

    // Single press of floor 5 with ready high: exact latency, then pop.
    req_ready = 1'b1;
    btn = 8'h20;
    repeat (LAT - 1) step();
    check("t1_valid_early", req_valid, 0);
    step();
    check("t1_valid_k3", req_valid, 0);
    step();
    check("t1_valid_k4", req_valid, 1);
    check("t1_floor", req_floor, 5);
    check("t1_count1", count, 1);
    check("t1_pending", pending, 8'h20);
    step();
    check("t1_count0", count, 0);
    check("t1_valid_off", req_valid, 0);
    check("t1_pending_kept", pending, 8'h20);
    btn = '0;
    service(3'd5);
    check("t1_svc_clear", pending, 0);
    repeat (LAT) step();

    // Floors 2 and 6 together with ready low: lowest first, then both popped in order.
    req_ready = 1'b0;
    btn = 8'h44;
    repeat (LAT) step();
    step();
    check("t2_floor_first", req_floor, 2);
    check("t2_count1", count, 1);
    step();
    check("t2_count2", count, 2);
    check("t2_pending", pending, 8'h44);
    check("t2_head_still2", req_floor, 2);
    btn = '0;
    req_ready = 1'b1;
    step();
    check("t2_floor_second", req_floor, 6);
    check("t2_count_after_pop", count, 1);
    check("t2_valid_second", req_valid, 1);
    step();
    check("t2_count0", count, 0);
    check("t2_valid_off", req_valid, 0);
    req_ready = 1'b0;
    service(3'd2);
    service(3'd6);
    check("t2_pending_clear", pending, 0);
    repeat (LAT) step();

    // Floor 3 queued then serviced before acceptance: stale entry dropped.
    btn = 8'h08;
    repeat (LAT + 1) step();
    check("t3_count1", count, 1);
    check("t3_floor", req_floor, 3);
    btn = '0;
    service(3'd3);
    check("t3_pending_clear", pending, 0);
    check("t3_valid_stale", req_valid, 0);
    check("t3_count_before_drop", count, 1);
    step();
    check("t3_count_dropped", count, 0);
    check("t3_valid_after", req_valid, 0);
    repeat (LAT) step();

    // Floor 4 pressed twice before pop: one FIFO entry.
    btn = 8'h10;
    repeat (LAT + 1) step();
    check("t4_count_first", count, 1);
    btn = '0;
    repeat (LAT + 2) step();
    btn = 8'h10;
    repeat (LAT + 2) step();
    check("t4_count_second", count, 1);
    check("t4_pending", pending, 8'h10);
    btn = '0;
    req_ready = 1'b1;
    step();
    check("t4_count_pop", count, 0);
    req_ready = 1'b0;
    service(3'd4);
    repeat (LAT) step();

    // Arrival of floor 1 and service of floor 1 on the same edge: set wins.
    btn = 8'h02;
    repeat (LAT) step();
    check("t5_pending_before", pending, 0);
    svc_valid = 1'b1;
    svc_floor = 3'd1;
    step();
    svc_valid = 1'b0;
    check("t5_set_wins", pending, 8'h02);
    check("t5_count", count, 1);
    req_ready = 1'b1;
    step();
    check("t5_count_pop", count, 0);
    req_ready = 1'b0;
    btn = '0;
    service(3'd1);
    check("t5_pending_clear", pending, 0);
    repeat (LAT) step();

    // Three queued entries cleared by async reset; held buttons give nothing afterwards.
    btn = 8'h8A;
    repeat (LAT + 3) step();
    check("t6_count3", count, 3);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_count", count, 0);
    check("t6_rst_pending", pending, 0);
    check("t6_rst_valid", req_valid, 0);
    check("t6_rst_floor", req_floor, 0);
    step();
    rst = 1'b0;
    repeat (LAT + 8) step();
    check("t6_held_count", count, 0);
    check("t6_held_pending", pending, 0);
    check("t6_held_valid", req_valid, 0);
    btn = '0;
    repeat (LAT) step();
    btn = 8'h01;
    repeat (LAT + 1) step();
    check("t6_fresh_valid", req_valid, 1);
    check("t6_fresh_floor", req_floor, 0);
    req_ready = 1'b1;
    step();
    check("t6_fresh_pop", count, 0);
    req_ready = 1'b0;
    btn = '0;
    service(3'd0);
    repeat (LAT) step();

    // All eight floors at once: fills to depth, pointers wrap, pops in floor order.
    btn = 8'hFF;
    repeat (LAT + 8) step();
    check("t7_full", count, 8);
    check("t7_head", req_floor, 0);
    check("t7_pending", pending, 8'hFF);
    btn = '0;
    req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t7_order_%0d", i), req_floor, i);
      step();
    end
    check("t7_empty", count, 0);
    check("t7_valid_off", req_valid, 0);
    req_ready = 1'b0;
    repeat (LAT) step();

`ifdef REQ_DEBOUNCE_EN
    // Short glitch is filtered; a six-cycle press yields one request.
    btn = 8'h02;
    repeat (2) step();
    btn = '0;
    repeat (16) step();
    check("t8_glitch_count", count, 0);
    btn = 8'h02;
    repeat (6) step();
    btn = '0;
    repeat (12) step();
    check("t8_press_count", count, 1);
    check("t8_press_floor", req_floor, 1);
`endif

    check("overflow_clear", overflow, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/call_request_queue.md
CALL_REQUEST_QUEUE -- requirements
Module: call_request_queue

Interface
REQ-001 Parameter NUM_FLOORS, default 8, SHALL set the number of floors and the width of btn, pending and queued.
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL equal NUM_FLOORS; elaboration SHALL fail otherwise.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the stable-cycle count used only when REQ_DEBOUNCE_EN is defined.
REQ-004 Port clk, input, 1: the single clock; every flop SHALL be clocked on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port btn, input, NUM_FLOORS: raw asynchronous call buttons, one per floor, high while pressed.
REQ-007 Port req_valid, output, 1: head request is presented on req_floor.
REQ-008 Port req_ready, input, 1: the elevator controller accepts the request.
REQ-009 Port req_floor, output, 4: requested floor number, zero-extended.
REQ-010 Port svc_valid, input, 1: the elevator reports a floor as serviced.
REQ-011 Port svc_floor, input, 3: the serviced floor.
REQ-012 Port pending, output, NUM_FLOORS: floors awaiting service.
REQ-013 Port count, output, 4: FIFO occupancy, 0..FIFO_DEPTH.
REQ-014 Port overflow, output, 1: sticky error flag.

Function
REQ-015 Each btn bit SHALL pass a 2-flop synchronizer and then a rising-edge detector, giving one press pulse per press.
REQ-016 Press pulses SHALL be OR-ed into an arrive register; each cycle, the lowest-indexed arrive bit SHALL be serviced and cleared, so at most one floor is serviced per cycle.
REQ-017 When floor f is serviced from arrive: pending[f] SHALL be set; if queued[f]=0, f SHALL be pushed to the FIFO and queued[f] set; if queued[f]=1, no push occurs.
REQ-018 Latency: btn high before edge k with an empty FIFO and no other arrivals SHALL give req_valid=1 after edge k+4.
REQ-019 req_valid SHALL equal (count!=0) && pending[head]; req_floor SHALL be the head entry.
REQ-020 A pop on req_valid && req_ready SHALL clear queued[head]; pending[head] SHALL remain set until serviced.
REQ-021 Stale head (count!=0 && !pending[head]) SHALL be dropped silently in one cycle: pop, clear queued, req_valid low that cycle.
REQ-022 svc_valid SHALL clear pending[svc_floor] at the next edge; svc of a non-pending floor SHALL be ignored.
REQ-023 A same-cycle arrive of floor f and svc of f: set SHALL win, so pending[f]=1.
REQ-024 A simultaneous push and pop SHALL leave count unchanged; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 A push attempted while count==FIFO_DEPTH SHALL be discarded and SHALL set overflow until reset (unreachable by design, kept defensive).
REQ-026 req_valid SHALL not depend combinationally on req_ready.

Reset
REQ-027 rst=1 SHALL immediately clear synchronizers, edge history, arrive, pending, queued, FIFO pointers, count and overflow; req_valid, req_floor and count SHALL read 0.
REQ-028 A button held through reset deassertion SHALL not generate a press, because edge history is reset low and the first synchronized high is treated as an edge only after a low is seen.

Configuration
REQ-029 With REQ_DEBOUNCE_EN defined, a synchronized btn bit SHALL be stable for DEBOUNCE_CYCLES consecutive cycles before its filtered level changes; the edge detector SHALL act on the filtered level, and REQ-018 latency SHALL become k+4+DEBOUNCE_CYCLES.
REQ-030 With REQ_DEBOUNCE_EN undefined, no debounce counters SHALL exist and the edge detector SHALL act on the synchronizer output.

Structure
REQ-031 Package elevator_pkg SHALL hold NUM_FLOORS, typedef floor_t (4-bit), and the elevator direction encoding (IDLE=00, DOWN=01, UP=11).
REQ-032 Sub-module btn_conditioner SHALL implement synchronizer, optional debounce and edge detect for one button, instantiated NUM_FLOORS times.

Verification
REQ-033 Press btn[5] once with req_ready=1 -> req_valid with req_floor=5 at edge k+4, pop, pending[5]=1, count=0.
REQ-034 Press btn[2] and btn[6] in the same cycle with req_ready=0 -> FIFO order 2 then 6, count=2, then pops in that order.
REQ-035 Queue floor 3 with req_ready=0, then svc_floor=3 -> pending[3]=0, entry dropped, req_valid never asserts for 3, count returns to 0.
REQ-036 Press floor 4 twice before it is popped -> single FIFO entry, count=1.
REQ-037 Assert rst with three entries queued -> count=0, pending=0, req_valid=0 immediately; a button held through reset produces no request.
REQ-038 With REQ_DEBOUNCE_EN defined, a 2-cycle btn[1] glitch -> no request; a 6-cycle press -> one request.
